// File: rtl/header_pkg.sv
// ---------------------------------------------------------------------------
// header_pkg
// Shared definitions for the header emission path: the source index map
// (index order is emission order), the scheduler FSM state type, and the
// registered set_bit bus record presented to the packer.
// ---------------------------------------------------------------------------
package header_pkg;

    // Number of header sub-generators feeding the shared set_bit bus
    localparam int NUM_SRC = 5;

    // Source indices, in the order they are granted the bus
    localparam int SRC_FRAME_HEADER     = 0;
    localparam int SRC_MATRIX           = 1;
    localparam int SRC_PICTURE_HEADER   = 2;
    localparam int SRC_SLICE_SIZE_TABLE = 3;
    localparam int SRC_SLICE_HEADER     = 4;

    // Width of the set_bit value and size fields
    localparam int SB_W = 64;

    // Scheduler states
    typedef enum logic [2:0] {
        ST_IDLE,
        ST_LAUNCH,
        ST_RUN,
        ST_NEXT,
        ST_FINISH
    } sched_state_t;

    // One beat of the set_bit bus
    typedef struct packed {
        logic            enable;
        logic [SB_W-1:0] val;
        logic [SB_W-1:0] size_of_bit;
        logic            flush;
    } sb_bus_t;

endpackage

// File: rtl/header_bit_counter.sv
// ---------------------------------------------------------------------------
// header_bit_counter
// Running bit position of the header stream plus per-source start offsets.
//
// Ports:
//   clock, reset   : system clock, synchronous active-high reset
//   clear          : zero the bit counter (start of a pass); offsets kept
//   add_en         : accepted set_bit enable this cycle
//   add_bits       : low 7 bits of the accepted size (0..64)
//   flush_en       : accepted byte-align request this cycle
//   capture_en     : latch current byte position for capture_idx
//   capture_idx    : source whose starting offset is being recorded
//   bit_cnt        : current bit position
//   offset_byte    : per-source byte offset where its output began
// ---------------------------------------------------------------------------
module header_bit_counter
#(
    parameter int NUM_SRC = 5,
    parameter int CNT_W   = 32,
    parameter int IDX_W   = 3
)
(
    input  logic                           clock,
    input  logic                           reset,
    input  logic                           clear,
    input  logic                           add_en,
    input  logic [6:0]                     add_bits,
    input  logic                           flush_en,
    input  logic                           capture_en,
    input  logic [IDX_W-1:0]               capture_idx,
    output logic [CNT_W-1:0]               bit_cnt,
    output logic [NUM_SRC-1:0][CNT_W-1:0]  offset_byte
);

    import header_pkg::*;

    logic [CNT_W-1:0]              cnt_q;
    logic [CNT_W-1:0]              cnt_sum;
    logic [CNT_W-1:0]              cnt_d;
    logic [NUM_SRC-1:0][CNT_W-1:0] offset_q;

    // Next bit position: the accepted size is added first and the flush
    // rounds the post-add value up to a byte boundary, so a beat carrying
    // both lands on the byte after its last bit. Arithmetic wraps at
    // 2^CNT_W. A new pass clears the counter regardless of bus activity.
    always_comb begin
        cnt_sum = cnt_q;
        if (add_en) begin
            cnt_sum = cnt_q + CNT_W'(add_bits);
        end
        cnt_d = cnt_sum;
        if (flush_en) begin
            cnt_d = (cnt_sum + CNT_W'(7)) & ~CNT_W'(7);
        end
        if (clear) begin
            cnt_d = '0;
        end
    end

    // Counter and offset registers. Offsets survive the start of a pass so
    // a skipped source keeps the value from the last pass it ran in; only
    // reset zeroes them.
    always_ff @(posedge clock) begin
        if (reset) begin
            cnt_q    <= '0;
            offset_q <= '0;
        end else begin
            cnt_q <= cnt_d;
            if (capture_en) begin
                offset_q[capture_idx] <= cnt_q >> 3;
            end
        end
    end

    assign bit_cnt     = cnt_q;
    assign offset_byte = offset_q;

endmodule

// File: rtl/header_emit_scheduler.sv
// ---------------------------------------------------------------------------
// header_emit_scheduler
// Grants the shared set_bit bus to the header sub-generators one at a time
// in index order, with a start/done handshake, and registers the muxed bus.
// The source at REPEAT_SRC is re-run slice_num times per pass. The running
// bit position and each source's starting byte offset are tracked for
// downstream back-patching.
//
// Ports:
//   clock, reset      : system clock, synchronous active-high reset
//   start             : pulse, begins a pass (ignored unless idle)
//   src_mask          : participating sources, sampled at start
//   slice_num         : repeat count for REPEAT_SRC, sampled at start
//   src_start         : one-hot launch pulse to the granted source
//   src_enable/val/size_of_bit/flush : per-source set_bit signals
//   src_done          : per-source completion pulse
//   sb_*              : registered set_bit bus towards the packer
//   src_offset_byte   : per-source starting byte offset
//   total_bit         : bits emitted this pass
//   busy, done, error : pass status; error is sticky until next start
// ---------------------------------------------------------------------------
module header_emit_scheduler
#(
    parameter int NUM_SRC        = 5,
    parameter int REPEAT_SRC     = 4,
    parameter int TIMEOUT_CYCLES = 4096,
    parameter int CNT_W          = 32
)
(
    input  logic                          clock,
    input  logic                          reset,
    input  logic                          start,
    input  logic [NUM_SRC-1:0]            src_mask,
    input  logic [15:0]                   slice_num,
    output logic [NUM_SRC-1:0]            src_start,
    input  logic [NUM_SRC-1:0]            src_enable,
    input  logic [NUM_SRC-1:0][63:0]      src_val,
    input  logic [NUM_SRC-1:0][63:0]      src_size_of_bit,
    input  logic [NUM_SRC-1:0]            src_flush,
    input  logic [NUM_SRC-1:0]            src_done,
    output logic                          sb_enable,
    output logic [63:0]                   sb_val,
    output logic [63:0]                   sb_size_of_bit,
    output logic                          sb_flush,
    output logic [NUM_SRC-1:0][CNT_W-1:0] src_offset_byte,
    output logic [CNT_W-1:0]              total_bit,
    output logic                          busy,
    output logic                          done,
    output logic                          error
);

    import header_pkg::*;

    localparam int IDX_W = (NUM_SRC > 1) ? $clog2(NUM_SRC) : 1;
    localparam int TMO_W = (TIMEOUT_CYCLES > 1) ? $clog2(TIMEOUT_CYCLES) : 1;
    localparam logic [TMO_W-1:0] TMO_LAST = TMO_W'(TIMEOUT_CYCLES - 1);

    sched_state_t       state_q, state_d;
    logic [IDX_W-1:0]   idx_q, idx_d;
    logic [NUM_SRC-1:0] mask_q, mask_d;
    logic [15:0]        rep_q, rep_d;
    logic [TMO_W-1:0]   tmo_q, tmo_d;
    logic               error_q, error_d;

    logic [NUM_SRC-1:0] eff_mask;
    logic [NUM_SRC-1:0] grant_vec;
    logic               granted;
    logic               cnt_clear;
    logic               capture_en;
    logic               add_en;
    logic               flush_en;
    sb_bus_t            sb_q, sb_d;
    logic [CNT_W-1:0]   bit_cnt;
    int                 nxt;

    // Lowest masked index strictly above 'after'; -1 when none remains.
    // Scanning downwards lets the lowest qualifying index win.
    function automatic int next_masked(input logic [NUM_SRC-1:0] mask,
                                       input int after);
        int r;
        r = -1;
        for (int i = NUM_SRC - 1; i >= 0; i--) begin
            if (i > after && mask[i]) begin
                r = i;
            end
        end
        return r;
    endfunction

    // The repeating source is dropped from the pass entirely when it has
    // zero repeats, which keeps its previous offset untouched.
    always_comb begin
        eff_mask = src_mask;
        if (slice_num == 16'd0) begin
            eff_mask[REPEAT_SRC] = 1'b0;
        end
    end

    // The bus belongs to a source only while its RUN state is active; the
    // launch and inter-source cycles carry nothing.
    always_comb begin
        granted   = (state_q == ST_RUN);
        grant_vec = '0;
        if (granted) begin
            grant_vec[idx_q] = 1'b1;
        end
        add_en   = granted & src_enable[idx_q];
        flush_en = granted & src_flush[idx_q];
    end

    // Bus mux: copy the granted source verbatim, otherwise drive an idle
    // beat. The register after this gives the one-cycle lag to sb_*.
    always_comb begin
        sb_d = '0;
        if (granted) begin
            sb_d.enable      = src_enable[idx_q];
            sb_d.val         = src_val[idx_q];
            sb_d.size_of_bit = src_size_of_bit[idx_q];
            sb_d.flush       = src_flush[idx_q];
        end
    end

    // FSM next-state and control. A src_done arriving with the final
    // enable still lets that enable through (the counter sees add_en this
    // same cycle) before moving to NEXT. A stalled source is force-advanced
    // after TIMEOUT_CYCLES RUN cycles and flagged, and the pass carries on.
    // The repeat counter is decremented on each launch of REPEAT_SRC so that
    // NEXT relaunches while repeats remain.
    always_comb begin
        state_d    = state_q;
        idx_d      = idx_q;
        mask_d     = mask_q;
        rep_d      = rep_q;
        tmo_d      = tmo_q;
        error_d    = error_q;
        cnt_clear  = 1'b0;
        capture_en = 1'b0;
        src_start  = '0;
        nxt        = -1;

        if (|(src_enable & ~grant_vec)) begin
            error_d = 1'b1;
        end

        unique case (state_q)
            ST_IDLE: begin
                if (start) begin
                    mask_d    = eff_mask;
                    rep_d     = slice_num;
                    error_d   = 1'b0;
                    cnt_clear = 1'b1;
                    nxt       = next_masked(eff_mask, -1);
                    if (nxt >= 0) begin
                        idx_d   = IDX_W'(nxt);
                        state_d = ST_LAUNCH;
                    end else begin
                        state_d = ST_FINISH;
                    end
                end
            end
            ST_LAUNCH: begin
                src_start[idx_q] = 1'b1;
                capture_en       = 1'b1;
                tmo_d            = '0;
                if (int'(idx_q) == REPEAT_SRC) begin
                    rep_d = rep_q - 16'd1;
                end
                state_d = ST_RUN;
            end
            ST_RUN: begin
                if (src_done[idx_q]) begin
                    state_d = ST_NEXT;
                end else if (tmo_q == TMO_LAST) begin
                    error_d = 1'b1;
                    state_d = ST_NEXT;
                end else begin
                    tmo_d = tmo_q + TMO_W'(1);
                end
            end
            ST_NEXT: begin
                if (int'(idx_q) == REPEAT_SRC && rep_q != 16'd0) begin
                    state_d = ST_LAUNCH;
                end else begin
                    nxt = next_masked(mask_q, int'(idx_q));
                    if (nxt >= 0) begin
                        idx_d   = IDX_W'(nxt);
                        state_d = ST_LAUNCH;
                    end else begin
                        state_d = ST_FINISH;
                    end
                end
            end
            ST_FINISH: begin
                state_d = ST_IDLE;
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    // State register; reset aborts any pass without a done pulse.
    always_ff @(posedge clock) begin
        if (reset) begin
            state_q <= ST_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // Pass context, timeout counter, sticky error and the registered bus.
    always_ff @(posedge clock) begin
        if (reset) begin
            idx_q   <= '0;
            mask_q  <= '0;
            rep_q   <= '0;
            tmo_q   <= '0;
            error_q <= 1'b0;
            sb_q    <= '0;
        end else begin
            idx_q   <= idx_d;
            mask_q  <= mask_d;
            rep_q   <= rep_d;
            tmo_q   <= tmo_d;
            error_q <= error_d;
            sb_q    <= sb_d;
        end
    end

    header_bit_counter #(
        .NUM_SRC (NUM_SRC),
        .CNT_W   (CNT_W),
        .IDX_W   (IDX_W)
    ) u_bit_counter (
        .clock       (clock),
        .reset       (reset),
        .clear       (cnt_clear),
        .add_en      (add_en),
        .add_bits    (src_size_of_bit[idx_q][6:0]),
        .flush_en    (flush_en),
        .capture_en  (capture_en),
        .capture_idx (idx_q),
        .bit_cnt     (bit_cnt),
        .offset_byte (src_offset_byte)
    );

    assign sb_enable      = sb_q.enable;
    assign sb_val         = sb_q.val;
    assign sb_size_of_bit = sb_q.size_of_bit;
    assign sb_flush       = sb_q.flush;
    assign total_bit      = bit_cnt;
    assign busy           = (state_q == ST_LAUNCH) || (state_q == ST_RUN) ||
                            (state_q == ST_NEXT);
    assign done           = (state_q == ST_FINISH);
    assign error          = error_q;

endmodule

// File: tb/tb_header_emit_scheduler.sv
// ---------------------------------------------------------------------------
// tb_header_emit_scheduler
// Drives randomized header passes into header_emit_scheduler. Expected bus
// beats and launch order go into queues as stimulus is issued; a monitor
// process compares them when the DUT presents them. Bit position and
// offsets come from a simple arithmetic model of the emitted beats.
// ---------------------------------------------------------------------------
module tb_header_emit_scheduler;

    localparam int NS = 5;
    localparam int CW = 32;

    localparam int M_RANDOM  = 0;
    localparam int M_FIXED   = 1;
    localparam int M_FLUSH   = 2;
    localparam int M_TIMEOUT = 3;
    localparam int M_ROGUE   = 4;
    localparam int M_RESET   = 5;

    logic                   clock = 1'b0;
    logic                   reset;
    logic                   start;
    logic [NS-1:0]          src_mask;
    logic [15:0]            slice_num;
    logic [NS-1:0]          src_start;
    logic [NS-1:0]          src_enable;
    logic [NS-1:0][63:0]    src_val;
    logic [NS-1:0][63:0]    src_size_of_bit;
    logic [NS-1:0]          src_flush;
    logic [NS-1:0]          src_done;
    logic                   sb_enable;
    logic [63:0]            sb_val;
    logic [63:0]            sb_size_of_bit;
    logic                   sb_flush;
    logic [NS-1:0][CW-1:0]  src_offset_byte;
    logic [CW-1:0]          total_bit;
    logic                   busy;
    logic                   done;
    logic                   error;

    header_emit_scheduler #(
        .NUM_SRC        (NS),
        .REPEAT_SRC     (4),
        .TIMEOUT_CYCLES (16),
        .CNT_W          (CW)
    ) dut (
        .clock           (clock),
        .reset           (reset),
        .start           (start),
        .src_mask        (src_mask),
        .slice_num       (slice_num),
        .src_start       (src_start),
        .src_enable      (src_enable),
        .src_val         (src_val),
        .src_size_of_bit (src_size_of_bit),
        .src_flush       (src_flush),
        .src_done        (src_done),
        .sb_enable       (sb_enable),
        .sb_val          (sb_val),
        .sb_size_of_bit  (sb_size_of_bit),
        .sb_flush        (sb_flush),
        .src_offset_byte (src_offset_byte),
        .total_bit       (total_bit),
        .busy            (busy),
        .done            (done),
        .error           (error)
    );

    typedef struct {
        int          cyc;
        logic        en;
        logic [63:0] val;
        logic [63:0] sz;
        logic        fl;
    } beat_t;

    beat_t       exp_sb[$];
    int          exp_launch[$];
    logic [31:0] exp_bc;
    logic [31:0] exp_off [NS];
    int          n_checks = 0;
    int          n_pass   = 0;
    int          done_cnt = 0;
    int          cyc      = 0;
    beat_t       mon_b;
    int          mon_s;

    // Free-running clock and cycle stamp used to verify the bus lag
    always #5 clock = ~clock;

    always @(posedge clock) cyc <= cyc + 1;

    task automatic checkOutput(input string name, input logic [63:0] actual,
                               input logic [63:0] expected);
        n_checks++;
        if (actual === expected) begin
            n_pass++;
        end else begin
            $display("[TB] FAIL %s: got 0x%0h, want 0x%0h", name, actual, expected);
        end
    endtask

    // Monitor: compares every bus beat and launch pulse the DUT presents
    // against the queues filled by the stimulus side, and counts done pulses
    always @(negedge clock) begin
        if (!reset) begin
            if (sb_enable || sb_flush) begin
                if (exp_sb.size() == 0) begin
                    checkOutput("sb_unexpected", {62'd0, sb_enable, sb_flush}, 64'd0);
                end else begin
                    mon_b = exp_sb.pop_front();
                    checkOutput("sb_lag", 64'(cyc), 64'(mon_b.cyc));
                    checkOutput("sb_flags", {62'd0, sb_enable, sb_flush},
                                {62'd0, mon_b.en, mon_b.fl});
                    checkOutput("sb_val", sb_val, mon_b.val);
                    checkOutput("sb_size", sb_size_of_bit, mon_b.sz);
                end
            end
            if (src_start != '0) begin
                if (exp_launch.size() == 0) begin
                    checkOutput("launch_unexpected", 64'(src_start), 64'd0);
                end else begin
                    mon_s = exp_launch.pop_front();
                    checkOutput("launch_order", 64'(src_start), 64'(5'b00001 << mon_s));
                end
            end
            if (done) done_cnt++;
        end
    end

    task automatic step();
        @(posedge clock);
        #1;
    endtask

    task automatic drive_idle();
        src_enable      = '0;
        src_val         = '0;
        src_size_of_bit = '0;
        src_flush       = '0;
        src_done        = '0;
    endtask

    // One bus beat from source s; the model advances the bit position by the
    // size when enabled, then rounds up to whole bytes when flushed
    task automatic issue_beat(input int s, input logic en, input logic [63:0] v,
                              input logic [63:0] sz, input logic fl, input logic dn);
        beat_t b;
        src_enable[s]      = en;
        src_val[s]         = v;
        src_size_of_bit[s] = sz;
        src_flush[s]       = fl;
        src_done[s]        = dn;
        b.cyc = cyc + 1;
        b.en  = en;
        b.val = v;
        b.sz  = sz;
        b.fl  = fl;
        exp_sb.push_back(b);
        if (en) exp_bc = exp_bc + sz[31:0];
        if (fl) exp_bc = ((exp_bc + 32'd7) / 32'd8) * 32'd8;
        step();
        drive_idle();
    endtask

    task automatic run_source(input int s, input int mode);
        int   nb;
        bit   dwl;
        logic en, fl;
        if (mode == M_FIXED) begin
            issue_beat(s, 1'b1, {$urandom, $urandom}, 64'd32, 1'b0, 1'b1);
        end else if (mode == M_FLUSH && s == 0) begin
            issue_beat(s, 1'b1, {$urandom, $urandom}, 64'd5, 1'b0, 1'b0);
            issue_beat(s, 1'b0, 64'd0, 64'd0, 1'b1, 1'b1);
        end else if (mode == M_FLUSH) begin
            src_done[s] = 1'b1;
            step();
            drive_idle();
        end else begin
            nb  = $urandom_range(0, 3);
            dwl = (nb > 0) && ($urandom_range(0, 1) == 1);
            for (int b = 0; b < nb; b++) begin
                if ($urandom_range(0, 3) == 0) step();
                en = ($urandom_range(0, 4) != 0);
                fl = en ? ($urandom_range(0, 3) == 0) : 1'b1;
                issue_beat(s, en, {$urandom, $urandom}, 64'($urandom_range(0, 64)),
                           fl, dwl && (b == nb - 1));
            end
            if (!dwl) begin
                src_done[s] = 1'b1;
                step();
                drive_idle();
            end
        end
    endtask

    task automatic wait_launch(output int when, output bit ok);
        ok   = 1'b0;
        when = 0;
        for (int i = 0; i < 64 && !ok; i++) begin
            @(negedge clock);
            if (src_start != '0) begin
                ok   = 1'b1;
                when = cyc;
            end
        end
    endtask

    task automatic clear_model();
        exp_bc = '0;
        for (int i = 0; i < NS; i++) exp_off[i] = '0;
    endtask

    // One full pass: the launch order is derived from the mask and repeat
    // count, each launch records its offset in the model, and the end-of-pass
    // status is compared against the model
    task automatic applyStimulus(input logic [NS-1:0] mask, input logic [15:0] sn,
                                 input int mode);
        int order[$];
        int lc, lc1, reps, done_before;
        bit ok;
        for (int s = 0; s < NS; s++) begin
            if (mask[s]) begin
                reps = (s == 4) ? int'(sn) : 1;
                for (int r = 0; r < reps; r++) order.push_back(s);
            end
        end
        foreach (order[k]) exp_launch.push_back(order[k]);
        done_before = done_cnt;
        exp_bc      = '0;
        lc1         = 0;

        src_mask  = mask;
        slice_num = sn;
        start     = 1'b1;
        step();
        start = 1'b0;

        foreach (order[k]) begin
            wait_launch(lc, ok);
            checkOutput("launch_seen", 64'(ok), 64'd1);
            if (!ok) begin
                exp_launch.delete();
                break;
            end
            if (k == 0) checkOutput("busy_on_launch", 64'(busy), 64'd1);
            exp_off[order[k]] = exp_bc >> 3;
            step();
            if (mode == M_RESET && order[k] == 2) begin
                reset = 1'b1;
                step();
                @(negedge clock);
                checkOutput("rst_sb", {sb_enable, sb_flush, sb_val, sb_size_of_bit != 64'd0}, '0);
                checkOutput("rst_status", {src_start, busy, done, error}, '0);
                checkOutput("rst_total", 64'(total_bit), 64'd0);
                checkOutput("rst_offsets", 64'(src_offset_byte), 64'd0);
                @(posedge clock);
                #1;
                reset = 1'b0;
                exp_launch.delete();
                exp_sb.delete();
                clear_model();
                step();
                checkOutput("no_done_on_abort", 64'(done_cnt), 64'(done_before));
                return;
            end
            if (mode == M_TIMEOUT && order[k] == 1) begin
                lc1 = lc;
            end else begin
                if (mode == M_TIMEOUT && order[k] == 2)
                    checkOutput("timeout_gap", 64'(lc - lc1), 64'd18);
                if (mode == M_ROGUE && order[k] == 1) begin
                    src_enable[3]      = 1'b1;
                    src_val[3]         = {$urandom, $urandom};
                    src_size_of_bit[3] = 64'd40;
                    step();
                    drive_idle();
                end
                run_source(order[k], mode);
            end
        end

        ok = 1'b0;
        for (int i = 0; i < 64 && !ok; i++) begin
            @(negedge clock);
            if (done) ok = 1'b1;
        end
        checkOutput("done_seen", 64'(ok), 64'd1);
        checkOutput("busy_at_done", 64'(busy), 64'd0);
        checkOutput("total_bit", 64'(total_bit), 64'(exp_bc));
        for (int i = 0; i < NS; i++)
            checkOutput($sformatf("offset_%0d", i), 64'(src_offset_byte[i]), 64'(exp_off[i]));
        checkOutput("error", 64'(error),
                    64'((mode == M_TIMEOUT || mode == M_ROGUE) ? 1 : 0));
        @(posedge clock);
        #1;
        step();
        step();
        checkOutput("done_once", 64'(done_cnt - done_before), 64'd1);
        checkOutput("queues_drained", 64'(exp_sb.size() + exp_launch.size()), 64'd0);
    endtask

    // Watchdog so the run always ends even if the DUT wedges
    initial begin
        #500000;
        $display("[TB] FAIL watchdog: simulation did not finish in time");
        $fatal(1, "[TB] watchdog expired");
    end

    // Main sequence: reset state, directed passes, random passes, abort
    initial begin
        reset     = 1'b1;
        start     = 1'b0;
        src_mask  = '0;
        slice_num = '0;
        drive_idle();
        clear_model();
        repeat (3) @(posedge clock);
        @(negedge clock);
        checkOutput("reset_sb", {sb_enable, sb_flush, sb_val, sb_size_of_bit != 64'd0}, '0);
        checkOutput("reset_status", {src_start, busy, done, error}, '0);
        checkOutput("reset_total", 64'(total_bit), 64'd0);
        @(posedge clock);
        #1;
        reset = 1'b0;
        step();

        $display("[TB] all sources, two slice repeats, 32-bit beats");
        applyStimulus(5'b11111, 16'd2, M_FIXED);
        checkOutput("t1_total_192", 64'(total_bit), 64'd192);
        checkOutput("t1_offset_4_is_20", 64'(src_offset_byte[4]), 64'd20);

        $display("[TB] 5 bits then flush on source 0");
        applyStimulus(5'b00011, 16'd1, M_FLUSH);
        checkOutput("t2_total_8", 64'(total_bit), 64'd8);
        checkOutput("t2_offset_1_is_1", 64'(src_offset_byte[1]), 64'd1);

        $display("[TB] sparse mask with zero slices");
        applyStimulus(5'b10101, 16'd0, M_RANDOM);

        $display("[TB] source 1 stalls until timeout");
        applyStimulus(5'b11111, 16'd1, M_TIMEOUT);

        $display("[TB] non-granted enable from source 3");
        applyStimulus(5'b11111, 16'd1, M_ROGUE);

        $display("[TB] random passes");
        for (int p = 0; p < 6; p++)
            applyStimulus(5'($urandom_range(1, 31)), 16'($urandom_range(0, 3)), M_RANDOM);

        $display("[TB] reset during source 2, then clean pass");
        applyStimulus(5'b11111, 16'd1, M_RESET);
        applyStimulus(5'b11111, 16'd1, M_RANDOM);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
